// File: rtl/cpu_pkg.sv
// cpu_pkg: shared CPU datapath widths and types used by the register file and ALU.
package cpu_pkg;
    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_NUM_REGS   = 32;
    localparam int REG_ADDR_WIDTH     = $clog2(DEFAULT_NUM_REGS);
    localparam int ZERO_REG           = 0;
    typedef logic [DEFAULT_DATA_WIDTH-1:0] word_t;
    typedef logic [REG_ADDR_WIDTH-1:0]     reg_addr_t;
endpackage

// File: rtl/regfile_read_port.sv
// regfile_read_port: registered read port with reg-0 masking and same-cycle write bypass.
module regfile_read_port
    import cpu_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = REG_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] read_addr,
    input  logic [DATA_WIDTH-1:0] array_data,
    input  logic                  reg_write,
    input  logic [ADDR_WIDTH-1:0] write_addr,
    input  logic [DATA_WIDTH-1:0] write_data,
    output logic [DATA_WIDTH-1:0] read_data
);
    logic                  bypass;
    logic [DATA_WIDTH-1:0] next_data;
    always_comb begin
        bypass    = reg_write && write_addr == read_addr && write_addr != ADDR_WIDTH'(ZERO_REG);
        next_data = read_addr == ADDR_WIDTH'(ZERO_REG) ? '0 : bypass ? write_data : array_data;
    end
    always_ff @(posedge clk) begin
        if (rst) read_data <= '0;
        else     read_data <= next_data;
    end
endmodule

// File: rtl/register_file.sv
// register_file: 2-read/1-write register file with registered reads and write-through bypass.
module register_file
    import cpu_pkg::*;
#(
    parameter  int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter  int NUM_REGS   = DEFAULT_NUM_REGS,
    localparam int ADDR_WIDTH = $clog2(NUM_REGS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  reg_write,
    input  logic [ADDR_WIDTH-1:0] write_addr,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic [ADDR_WIDTH-1:0] read_addr_a,
    input  logic [ADDR_WIDTH-1:0] read_addr_b,
    output logic [DATA_WIDTH-1:0] read_data_a,
    output logic [DATA_WIDTH-1:0] read_data_b
);
    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    always_ff @(posedge clk) begin
        if (rst) for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        else if (reg_write && write_addr != ADDR_WIDTH'(ZERO_REG)) regs[write_addr] <= write_data;
    end
    regfile_read_port #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) port_a (
        .clk(clk), .rst(rst), .read_addr(read_addr_a), .array_data(regs[read_addr_a]),
        .reg_write(reg_write), .write_addr(write_addr), .write_data(write_data),
        .read_data(read_data_a)
    );
    regfile_read_port #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) port_b (
        .clk(clk), .rst(rst), .read_addr(read_addr_b), .array_data(regs[read_addr_b]),
        .reg_write(reg_write), .write_addr(write_addr), .write_data(write_data),
        .read_data(read_data_b)
    );
endmodule

// File: tb/tb_register_file.sv
// tb_register_file: directed plan cases plus random traffic checked against an array model.
module tb_register_file;
    logic        clk = 0;
    logic        rst = 1;
    logic        reg_write = 0;
    logic [4:0]  write_addr = 0;
    logic [31:0] write_data = 0;
    logic [4:0]  read_addr_a = 0;
    logic [4:0]  read_addr_b = 0;
    logic [31:0] read_data_a;
    logic [31:0] read_data_b;
    int          total = 0;
    int          bad = 0;
    bit          armed = 0;
    logic [31:0] model [32];
    logic [31:0] exp_a, exp_b;

    register_file dut (
        .clk(clk), .rst(rst), .reg_write(reg_write), .write_addr(write_addr),
        .write_data(write_data), .read_addr_a(read_addr_a), .read_addr_b(read_addr_b),
        .read_data_a(read_data_a), .read_data_b(read_data_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    // The model applies the write first, so a same-cycle read naturally sees the new value.
    task automatic step(input string tag, input logic r, input logic we, input logic [4:0] wa,
                        input logic [31:0] wd, input logic [4:0] ra, input logic [4:0] rb);
        rst = r; reg_write = we; write_addr = wa; write_data = wd;
        read_addr_a = ra; read_addr_b = rb;
        #2;
        if (armed) begin
            check({tag, "_hold_a"}, read_data_a, exp_a);
            check({tag, "_hold_b"}, read_data_b, exp_b);
        end
        @(posedge clk);
        if (r) for (int i = 0; i < 32; i++) model[i] = 0;
        else if (we && wa != 0) model[wa] = wd;
        exp_a = r ? 32'h0 : model[ra];
        exp_b = r ? 32'h0 : model[rb];
        #1;
        armed = 1;
        check({tag, "_a"}, read_data_a, exp_a);
        check({tag, "_b"}, read_data_b, exp_b);
    endtask

    initial begin
        logic [31:0] alu_res;
        for (int i = 0; i < 32; i++) model[i] = 0;
        @(negedge clk);
        step("init_rst", 1, 0, 0, 0, 0, 0);
        step("w5", 0, 1, 5, 32'hDEADBEEF, 0, 0);
        step("rst", 1, 1, 6, 32'h1234, 5, 5);
        check("rst_b_zero", read_data_b, 32'h0);
        step("rd5", 0, 0, 0, 0, 5, 0);
        check("rst_reg5_zero", read_data_a, 32'h0);
        step("w3", 0, 1, 3, 32'h11, 0, 0);
        check("lat_not_yet", read_data_a, 32'h0);
        step("rd3", 0, 0, 0, 0, 3, 0);
        check("lat_reg3", read_data_a, 32'h11);
        step("w7", 0, 1, 7, 32'hAAAAAAAA, 0, 0);
        step("byp", 0, 1, 7, 32'h12345678, 7, 7);
        check("bypass_a", read_data_a, 32'h12345678);
        check("bypass_b", read_data_b, 32'h12345678);
        step("w0", 0, 1, 0, 32'hFFFFFFFF, 0, 0);
        check("reg0_same", read_data_a, 32'h0);
        step("r0", 0, 0, 0, 0, 0, 0);
        check("reg0_next", read_data_a, 32'h0);
        step("w31", 0, 1, 31, 32'h1, 0, 0);
        step("w1", 0, 1, 1, 32'h2, 0, 0);
        step("bnd", 0, 1, 1, 32'h3, 31, 1);
        check("bnd_a31", read_data_a, 32'h1);
        check("bnd_b1", read_data_b, 32'h3);
        step("alu_w1", 0, 1, 1, 32'd5, 0, 0);
        step("alu_w2", 0, 1, 2, 32'd5, 0, 0);
        step("alu_rd", 0, 0, 0, 0, 1, 2);
        alu_res = read_data_a - read_data_b;
        check("alu_zero", {31'b0, alu_res == 0}, 32'h1);
        step("alu_wb", 0, 1, 4, exp_a - exp_b, 0, 0);
        step("alu_rd4", 0, 0, 0, 0, 4, 4);
        check("alu_reg4", read_data_a, 32'h0);
        for (int n = 0; n < 400; n++) begin
            logic [4:0] wa, ra, rb;
            wa = 5'($urandom);
            ra = ($urandom % 4 == 0) ? wa : 5'($urandom);
            rb = ($urandom % 4 == 0) ? wa : ($urandom % 4 == 0) ? ra : 5'($urandom);
            step("rnd", $urandom % 50 == 0, 1'($urandom), wa, $urandom, ra, rb);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/register_file.md
Name: register_file

Overview:
- Two-read/one-write general-purpose register file, directly upstream of the ALU.
- Read ports drive the ALU A and B operand buses; the write port takes the ALU result, or any other writeback source, back into the array.
- Reads are registered, so operands arrive one clock after their addresses are presented, aligned with the ALU's clocked operation.
- Register 0 is hardwired to zero.

Parameters:
- DATA_WIDTH, 32, width of each register and of the data buses.
- NUM_REGS, 32, number of registers; must be a power of two, minimum 2.
- ADDR_WIDTH, $clog2(NUM_REGS), width of register addresses; derived, not overridden.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- reg_write  input  1  write enable for the write port.
- write_addr  input  ADDR_WIDTH  destination register.
- write_data  input  DATA_WIDTH  data to write; normally the ALU result.
- read_addr_a  input  ADDR_WIDTH  source register for operand A.
- read_addr_b  input  ADDR_WIDTH  source register for operand B.
- read_data_a  output  DATA_WIDTH  registered operand A, feeds ALU A.
- read_data_b  output  DATA_WIDTH  registered operand B, feeds ALU B.

Behaviour:
- Reset:
  - When rst is high at a rising edge, every register, read_data_a and read_data_b become 0.
  - Writes and reads in that cycle are ignored.
  - A reset mid-operation discards any in-flight write.
- Write:
  - At a rising edge with rst=0 and reg_write=1, regs[write_addr] <= write_data.
  - Writes to address 0 are discarded; reg 0 always reads 0.
- Read:
  - At every rising edge with rst=0, read_data_a <= value of regs[read_addr_a], and likewise for B.
  - Latency is exactly 1 cycle from address to data.
  - Outputs hold between edges and change only at edges.
- Bypass (write-through):
  - Condition: reg_write=1, write_addr == read_addr_x, and write_addr != 0, all in the same cycle.
  - read_data_x captures write_data, not the old array contents.
  - Read-after-write in the same cycle returns new data.
  - Applies independently to A and B; both may bypass at once.
- Address 0 read: always returns 0, including when a write to address 0 happens in the same cycle.
- Same address on both read ports: both outputs are identical, including under bypass.
- Widths: no arithmetic or truncation; addresses are full-range, and every value 0..NUM_REGS-1 is legal.
- No handshake, stall or backpressure; the block accepts one write and two reads every cycle.
- No X propagation after reset: all storage is explicitly reset. There is no initial block.

Decomposition:
- Shared package cpu_pkg:
  - DATA_WIDTH and NUM_REGS defaults.
  - typedef word_t (logic [DATA_WIDTH-1:0]).
  - typedef reg_addr_t (logic [ADDR_WIDTH-1:0]).
  - localparam ZERO_REG = 0.
- The ALU also takes word_t for A, B and result from this package.
- One sub-module is natural: regfile_read_port.
  - Instantiated twice, once per read port.
  - Contains the address-0 masking, the bypass compare and mux, and the output register.
  - The top level holds the array and the write logic.

Test Plan:
- Reset:
  - Stimulus: write 0xDEADBEEF to reg 5, then assert rst for 1 cycle, then read reg 5 on port A.
  - Required response: read_data_a = 0x00000000 one cycle after the address, and read_data_b = 0 during reset.
- Basic write/read latency:
  - Stimulus: write 0x00000011 to reg 3 in cycle n; in cycle n+1 set read_addr_a=3.
  - Required response: read_data_a = 0x00000011 after edge n+2, and it is not valid before that edge.
- Bypass:
  - Stimulus: in one cycle, write 0x12345678 to reg 7 while read_addr_a=7 and read_addr_b=7 (reg 7 previously held 0xAAAAAAAA).
  - Required response: both outputs = 0x12345678 after that edge.
- Register 0:
  - Stimulus: write 0xFFFFFFFF to reg 0 while read_addr_a=0; then read reg 0 again the next cycle.
  - Required response: read_data_a = 0 both times.
- Independent ports plus boundary address:
  - Stimulus: write 0x1 to reg 31 and 0x2 to reg 1 on successive cycles; then set read_addr_a=31 and read_addr_b=1 while a write of 0x3 to reg 1 occurs.
  - Required response: read_data_a = 0x1 and read_data_b = 0x3.
- ALU hookup:
  - Stimulus: reg1 = 5, reg2 = 5; read them on ports A/B into the ALU with subtract op 3'b110; write the result to reg 4.
  - Required response: the ALU zero flag sets, and a subsequent read of reg 4 returns 0.
